// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial sequence detector.
// Overlap/non-overlap selectable, with a saturating match counter.
module seq_detect_prog #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               res,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed,
  output logic               cfg_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_TOP = '1;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN-1:0] mask;
  logic               accept;
  logic               hit;
  logic               len_ok;

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign hist_n = {hist_q[MAX_LEN-2:0], x};
  assign fill_n = (fill_q == LEN_MAX) ? fill_q : fill_q + 1'b1;
  assign accept = (state_q == RUN) && x_valid && !cfg_load;
  // pattern bits at or above len_q are masked out
  assign hit    = accept && (fill_n >= len_q) &&
                  (((hist_n ^ pat_q) & mask) == '0);
  assign len_ok = (cfg_len != '0) && (cfg_len <= LEN_MAX);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (cfg_load) begin
      pat_d   = cfg_pattern;
      len_d   = cfg_len;
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      cnt_d   = '0;
      state_d = len_ok ? RUN : IDLE;
      err_d   = !len_ok;
    end else begin
      if (cnt_clr) cnt_d = '0;
      if (accept) begin
        hist_d = hist_n;
        fill_d = fill_n;
      end
      if (hit) begin
        match_d = 1'b1;
        if (cnt_clr)              cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_TOP) cnt_d = cnt_q + 1'b1;
        if (!ovl_q) fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign armed     = (state_q == RUN);
  assign cfg_err   = err_q;

endmodule
